// File: rtl/acc_pkg.sv
// Shared types and defaults for the matrix accelerator sequencer.
// The sequencer FSM state set and the datapath enable/finish strobe values live here.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } acc_state_e;

   localparam int   ACC_NUM_COLS  = 8;
   localparam int   ACC_TIMEOUT   = 1024;

   localparam logic ACC_EN_VALUE  = 1'b1;
   localparam logic ACC_END_VALUE = 1'b1;

endpackage

// File: rtl/acc_seq_ctrl_watchdog.sv
// Stall watchdog for the accelerator sequencer, built only with ACC_SEQ_TIMEOUT_EN.
// Counts enabled cycles since the last clear and flags expiry on the LIMIT-th cycle.
`ifdef ACC_SEQ_TIMEOUT_EN
module seq_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt_r;
   logic             expire_s;

   // Expiry is flagged while the LIMIT-th stalled cycle is in progress
   always_comb begin
      expire_s = 1'b0;
      if (enable && (cnt_r == CNT_W'(LIMIT - 1))) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Stall cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (enable && !expire_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = expire_s;

endmodule
`endif

// File: rtl/acc_seq_ctrl.sv
// Load/compute sequencer for the matrix accelerator with APB wait-state generation.
// Optional stall watchdog is enabled by defining ACC_SEQ_TIMEOUT_EN.
module acc_seq_ctrl
   import acc_pkg::*;
#(
   parameter int NUM_COLS = ACC_NUM_COLS,
   parameter int COL_W    = 3,
   parameter int TIMEOUT  = ACC_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic             abort_in,
   input  logic             load_done,
   input  logic             cal_finish,
   output logic             load_en,
   output logic             ALU_en,
   output logic [COL_W-1:0] col_counter,
   output logic             acc_finish,
   output logic             pready,
   output logic             busy,
   output logic             err
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   acc_state_e       state_r, state_s;
   logic [COL_W-1:0] col_r, col_s;
   logic             err_r, err_s;
   logic             wd_expire_s;
   logic             load_en_r, alu_en_r, acc_finish_r, pready_r, busy_r;

`ifdef ACC_SEQ_TIMEOUT_EN
   logic wd_enable_s;
   logic wd_clear_s;

   // Watchdog runs only in the active phases and restarts on every forward step
   always_comb begin
      wd_enable_s = (state_r == LOAD) || (state_r == CALC);
      wd_clear_s  = (!wd_enable_s) ||
                    ((state_r == LOAD) && load_done) ||
                    ((state_r == CALC) && cal_finish);
   end

   seq_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear_s),
      .enable (wd_enable_s),
      .expire (wd_expire_s)
   );
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT != 0);
   assign wd_expire_s      = 1'b0;
`endif

   // Next-state, column index and sticky error; abort outranks watchdog outranks progress
   always_comb begin
      state_s = state_r;
      col_s   = col_r;
      err_s   = err_r;
      if (abort_in) begin
         state_s = IDLE;
         col_s   = {COL_W{1'b0}};
      end else if (wd_expire_s) begin
         state_s = IDLE;
         col_s   = {COL_W{1'b0}};
         err_s   = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_in) begin
                  state_s = LOAD;
                  col_s   = {COL_W{1'b0}};
                  err_s   = 1'b0;
               end else begin
                  state_s = IDLE;
               end
            end
            LOAD: begin
               if (load_done) begin
                  state_s = CALC;
                  col_s   = {COL_W{1'b0}};
               end else begin
                  state_s = LOAD;
               end
            end
            CALC: begin
               if (cal_finish && (col_r == LAST_COL)) begin
                  state_s = DONE;
               end else if (cal_finish) begin
                  col_s = col_r + COL_W'(1);
               end else begin
                  state_s = CALC;
               end
            end
            DONE: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
               col_s   = {COL_W{1'b0}};
            end
         endcase
      end
   end

   // State, counter and outputs registered together so outputs track the state they decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         col_r        <= {COL_W{1'b0}};
         err_r        <= 1'b0;
         load_en_r    <= ~ACC_EN_VALUE;
         alu_en_r     <= ~ACC_EN_VALUE;
         acc_finish_r <= ~ACC_END_VALUE;
         pready_r     <= 1'b1;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         col_r        <= col_s;
         err_r        <= err_s;
         load_en_r    <= (state_s == LOAD) ? ACC_EN_VALUE : ~ACC_EN_VALUE;
         alu_en_r     <= (state_s == CALC) ? ACC_EN_VALUE : ~ACC_EN_VALUE;
         acc_finish_r <= (state_s == DONE) ? ACC_END_VALUE : ~ACC_END_VALUE;
         pready_r     <= !((state_s == LOAD) || (state_s == CALC));
         busy_r       <= (state_s == LOAD) || (state_s == CALC);
      end
   end

   assign load_en     = load_en_r;
   assign ALU_en      = alu_en_r;
   assign col_counter = col_r;
   assign acc_finish  = acc_finish_r;
   assign pready      = pready_r;
   assign busy        = busy_r;
   assign err         = err_r;

endmodule
